poly_phase_ctrl: RTL and testbench
==================================

Name: poly_phase_ctrl

Overview:
Parametrised successor of the fixed 4-phase polyphase control counter. It generates the phase counter and the per-symbol strobes used by the polyphase filter, the rate-1 path and the FSE shifters, for any even oversampling factor. It adds a clock enable and slip/stuff phase adjustment requests, so the symbol-timing recovery loop can shorten or lengthen one symbol period. It sits at the top of the receive datapath and feeds every rate-decimated block.

Parameters:
OS_FACTOR, 4, phases per symbol; even, >=4, <=2**CNT_W
CNT_W, 2, counter width
RESET_PHASE, 2, counter value loaded on reset; range 0..OS_FACTOR-1
RATE1_PHASE, 2, counter value on which o_count_max_rate1 fires; range 1..OS_FACTOR-1

Ports:
clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_enable  in  1  advance enable; low freezes all state
i_slip  in  1  request: drop phase 0 at the next wrap (symbol shortened by 1)
i_stuff  in  1  request: repeat phase 0 at the next wrap (symbol lengthened by 1)
o_counter  out  CNT_W  current phase
o_count_max  out  1  high while o_counter==OS_FACTOR-1
o_count_half_or_max  out  1  high while o_counter==OS_FACTOR/2-1 or OS_FACTOR-1
o_count_max_rate1  out  1  high while o_counter==RATE1_PHASE
o_save_fse_shifters  out  1  identical to o_count_max
o_adj_pending  out  1  a slip or stuff is queued
o_adj_done  out  1  one-cycle pulse when the queued adjustment takes effect
o_phase_acc  out  16  net slips minus stuffs (optional feature)

Behaviour:
- Reset:
  - o_counter=RESET_PHASE.
  - All strobes, o_adj_pending, o_adj_done and the hold flag = 0.
  - o_phase_acc = 0.
  - Reset overrides i_enable and any request; a queued request is discarded.
- i_enable=0:
  - Counter, pending and hold state are frozen.
  - All strobes and o_adj_done are 0 on the next edge.
  - Requests are still captured into pending.
- Next counter (nxt), evaluated when i_enable=1:
  - hold flag set: nxt=0, then clear hold.
  - Else if counter==OS_FACTOR-1 and slip is effective: nxt=1.
  - Else if counter==OS_FACTOR-1 and stuff is effective: nxt=0, set hold.
  - Else if counter==OS_FACTOR-1: nxt=0.
  - Else: nxt=counter+1.
- "Effective" means pending, or requested in the same cycle; a request coincident with the wrap applies at that wrap.
- Strobes are registered compares on nxt, so each is aligned with the o_counter value it decodes (zero extra latency vs o_counter).
  - The repeated phase 0 during a stuff fires no strobe, since all strobe phases are >=1.
- Pending queue, one entry:
  - Request of the same type while pending: dropped.
  - Opposite type while pending, or i_slip and i_stuff together: pending cleared, no adjustment, no o_adj_done.
- o_adj_done pulses in the cycle o_counter first shows the adjusted value: 1 for a slip, the first 0 for a stuff. Pending clears at that edge.
- Symbol period between o_count_max pulses:
  - Nominal: OS_FACTOR cycles.
  - Slip: OS_FACTOR-1 cycles.
  - Stuff: OS_FACTOR+1 cycles.
  - At most one adjustment per symbol.
- Counter never leaves 0..OS_FACTOR-1.

Optional Feature:
- Macro PHASE_ACC_EN.
- Defined: o_phase_acc is a 16-bit signed accumulator.
  - +1 on each applied slip, -1 on each applied stuff.
  - Saturates at +32767 / -32768.
  - Cleared by reset.
- Undefined: o_phase_acc is tied to 0 and no accumulator register is built.

Test Plan:
- Defaults, release reset, i_enable=1 -> o_counter 2,3,0,1,2,3...; o_count_max high only with counter 3, every 4 cycles; o_count_half_or_max high on 1 and 3; o_count_max_rate1 on 2; o_save_fse_shifters==o_count_max.
- i_slip pulse at counter 0 -> o_adj_pending=1 until wrap; sequence 3,1,2,3; o_adj_done with the 1; o_count_max gap of 3 cycles; o_phase_acc=+1.
- i_stuff pulse coincident with counter 3 -> sequence 3,0,0,1,2,3; o_adj_done with the first 0; o_count_max gap of 5 cycles; o_phase_acc=-1.
- i_slip then i_stuff before the wrap, and a separate run with both in the same cycle -> pending cleared, nominal period 4, no o_adj_done, o_phase_acc unchanged.
- OS_FACTOR=8, CNT_W=3, RATE1_PHASE=5; i_enable low 3 cycles at counter 6 -> counter holds 6 with strobes 0, then resumes 7 (max and half both high), 0; half also high at 3; rate1 at 5.
- Assert i_reset mid-stuff, while the hold flag is set -> next cycle o_counter=RESET_PHASE, all strobes/pending/o_adj_done 0, o_phase_acc=0.

Source files
------------

// File: rtl/poly_phase_ctrl.sv
// poly_phase_ctrl: polyphase phase counter and per-symbol strobes with slip/stuff adjustment
// Ports: clk, i_reset (sync, active-high), i_enable (advance), i_slip/i_stuff (adjust requests),
//        o_counter (phase), o_count_max, o_count_half_or_max, o_count_max_rate1, o_save_fse_shifters
//        (decoded strobes aligned with o_counter), o_adj_pending, o_adj_done, o_phase_acc.
// Optional: define PHASE_ACC_EN to build the saturating 16-bit net slip-minus-stuff accumulator.
module poly_phase_ctrl #(
    parameter int OS_FACTOR   = 4,
    parameter int CNT_W       = 2,
    parameter int RESET_PHASE = 2,
    parameter int RATE1_PHASE = 2
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_slip,
    input  logic             i_stuff,
    output logic [CNT_W-1:0] o_counter,
    output logic             o_count_max,
    output logic             o_count_half_or_max,
    output logic             o_count_max_rate1,
    output logic             o_save_fse_shifters,
    output logic             o_adj_pending,
    output logic             o_adj_done,
    output logic [15:0]      o_phase_acc
);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(OS_FACTOR - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(OS_FACTOR / 2 - 1);
    localparam logic [CNT_W-1:0] R1   = CNT_W'(RATE1_PHASE);
    localparam logic [CNT_W-1:0] RST  = CNT_W'(RESET_PHASE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic hold_q, hold_d, pslip_q, pslip_d, pstuff_q, pstuff_d;
    logic max_q, half_q, r1_q, done_q;
    logic eff_slip, eff_stuff, wrap, app_slip, app_stuff;

    always_comb begin
        // an opposite request, or both at once, cancels the queue; a same-type repeat is absorbed
        eff_slip  = pslip_q  ? !i_stuff : (i_slip  && !i_stuff && !pstuff_q);
        eff_stuff = pstuff_q ? !i_slip  : (i_stuff && !i_slip  && !pslip_q);
        wrap      = i_enable && !hold_q && cnt_q == MAX;
        app_slip  = wrap && eff_slip;
        app_stuff = wrap && eff_stuff;
        cnt_d     = !i_enable ? cnt_q :
                    hold_q    ? '0 :
                    app_slip  ? CNT_W'(1) :
                    wrap      ? '0 : cnt_q + 1'b1;
        hold_d    = i_enable ? app_stuff : hold_q;
        pslip_d   = eff_slip && !wrap;
        pstuff_d  = eff_stuff && !wrap;
    end

    // strobes decode the next counter value so they line up with o_counter
    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q    <= RST;
            hold_q   <= 1'b0;
            pslip_q  <= 1'b0;
            pstuff_q <= 1'b0;
            max_q    <= 1'b0;
            half_q   <= 1'b0;
            r1_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            pslip_q  <= pslip_d;
            pstuff_q <= pstuff_d;
            max_q    <= i_enable && cnt_d == MAX;
            half_q   <= i_enable && (cnt_d == HALF || cnt_d == MAX);
            r1_q     <= i_enable && cnt_d == R1;
            done_q   <= app_slip || app_stuff;
        end
    end

`ifdef PHASE_ACC_EN
    logic [15:0] acc_q;
    always_ff @(posedge clk) begin
        if (i_reset)
            acc_q <= '0;
        else if (app_slip && acc_q != 16'h7fff)
            acc_q <= acc_q + 16'd1;
        else if (app_stuff && acc_q != 16'h8000)
            acc_q <= acc_q - 16'd1;
    end
    assign o_phase_acc = acc_q;
`else
    assign o_phase_acc = '0;
`endif

    assign o_counter           = cnt_q;
    assign o_count_max         = max_q;
    assign o_count_half_or_max = half_q;
    assign o_count_max_rate1   = r1_q;
    assign o_save_fse_shifters = max_q;
    assign o_adj_pending       = pslip_q || pstuff_q;
    assign o_adj_done          = done_q;
endmodule

// File: tb/tb_poly_phase_ctrl.sv
// tb_poly_phase_ctrl: randomized and directed check of poly_phase_ctrl against a behavioural model
module tb_poly_phase_ctrl;
    logic clk = 1'b0;
    logic rst, en, slip, stuff;
    logic [1:0] c4;
    logic [2:0] c8;
    logic mx4, hf4, r14, sv4, pd4, dn4;
    logic mx8, hf8, r18, sv8, pd8, dn8;
    logic [15:0] ac4, ac8;
    int errors = 0, checks = 0;
    int m_cnt[2], m_pend[2], m_acc[2];
    bit m_rep[2], m_live[2], m_done[2];
    int os_f[2] = '{4, 8};
    int r1_f[2] = '{2, 5};

    always #5 clk = ~clk;

    poly_phase_ctrl dut4 (
        .clk(clk), .i_reset(rst), .i_enable(en), .i_slip(slip), .i_stuff(stuff),
        .o_counter(c4), .o_count_max(mx4), .o_count_half_or_max(hf4),
        .o_count_max_rate1(r14), .o_save_fse_shifters(sv4),
        .o_adj_pending(pd4), .o_adj_done(dn4), .o_phase_acc(ac4)
    );

    poly_phase_ctrl #(.OS_FACTOR(8), .CNT_W(3), .RESET_PHASE(2), .RATE1_PHASE(5)) dut8 (
        .clk(clk), .i_reset(rst), .i_enable(en), .i_slip(slip), .i_stuff(stuff),
        .o_counter(c8), .o_count_max(mx8), .o_count_half_or_max(hf8),
        .o_count_max_rate1(r18), .o_save_fse_shifters(sv8),
        .o_adj_pending(pd8), .o_adj_done(dn8), .o_phase_acc(ac8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // symbol-level model: a one-entry request queue and a phase that wraps, skips or repeats 0
    task automatic model(input int k);
        int req;
        if (rst) begin
            m_cnt[k] = 2; m_pend[k] = 0; m_rep[k] = 0; m_live[k] = 0; m_done[k] = 0; m_acc[k] = 0;
            return;
        end
        req = (slip && stuff) ? 2 : slip ? 1 : stuff ? -1 : 0;
        if (req == 2) m_pend[k] = 0;
        else if (req != 0) m_pend[k] = (m_pend[k] == 0 || m_pend[k] == req) ? req : 0;
        m_live[k] = en;
        m_done[k] = 0;
        if (!en) return;
        if (m_rep[k]) begin
            m_rep[k] = 0;
            m_cnt[k] = 0;
        end else if (m_cnt[k] == os_f[k] - 1) begin
            if (m_pend[k] == 1) begin
                m_cnt[k] = 1; m_done[k] = 1;
                if (m_acc[k] < 32767) m_acc[k]++;
            end else if (m_pend[k] == -1) begin
                m_cnt[k] = 0; m_rep[k] = 1; m_done[k] = 1;
                if (m_acc[k] > -32768) m_acc[k]--;
            end else m_cnt[k] = 0;
            m_pend[k] = 0;
        end else m_cnt[k]++;
    endtask

    task automatic check_dut(input int k, input logic [31:0] cnt, input logic mx, hf, r1, sv, pd, dn,
                             input logic [15:0] ac);
        int n;
        bit lv;
        logic [31:0] ea;
        n = os_f[k];
        lv = m_live[k];
        ea = 0;
`ifdef PHASE_ACC_EN
        ea = m_acc[k] & 32'hffff;
`endif
        check($sformatf("os%0d counter", n), cnt, m_cnt[k]);
        check($sformatf("os%0d max", n), mx, lv && m_cnt[k] == n - 1);
        check($sformatf("os%0d half_or_max", n), hf, lv && (m_cnt[k] == n / 2 - 1 || m_cnt[k] == n - 1));
        check($sformatf("os%0d rate1", n), r1, lv && m_cnt[k] == r1_f[k]);
        check($sformatf("os%0d save_fse", n), sv, lv && m_cnt[k] == n - 1);
        check($sformatf("os%0d pending", n), pd, m_pend[k] != 0);
        check($sformatf("os%0d adj_done", n), dn, m_done[k]);
        check($sformatf("os%0d phase_acc", n), {16'd0, ac}, ea);
    endtask

    task automatic step(input logic r, e, sl, st);
        rst = r; en = e; slip = sl; stuff = st;
        @(posedge clk);
        model(0);
        model(1);
        #1;
        check_dut(0, c4, mx4, hf4, r14, sv4, pd4, dn4, ac4);
        check_dut(1, c8, mx8, hf8, r18, sv8, pd8, dn8, ac8);
    endtask

    task automatic run_until(input int k, input int v);
        for (int i = 0; i < 20; i++) begin
            if (m_cnt[k] == v) break;
            step(0, 1, 0, 0);
        end
    endtask

    initial begin
        rst = 1; en = 0; slip = 0; stuff = 0;
        repeat (2) step(1, 0, 0, 0);
        repeat (12) step(0, 1, 0, 0);
        run_until(0, 0);
        step(0, 1, 1, 0);
        repeat (8) step(0, 1, 0, 0);
        run_until(0, 3);
        step(0, 1, 0, 1);
        repeat (8) step(0, 1, 0, 0);
        run_until(0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 1);
        repeat (6) step(0, 1, 0, 0);
        run_until(0, 1);
        step(0, 1, 1, 1);
        repeat (6) step(0, 1, 0, 0);
        run_until(1, 6);
        repeat (3) step(0, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        run_until(0, 3);
        step(0, 1, 0, 1);
        step(1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
